// File: rtl/vector_lane_sequencer_if.sv
// ---------------------------------------------------------------------------
// vector_lane_sequencer_if
//   Handshake bundle between the Execute-stage control (hazard unit, decode
//   of the vector instruction, data memory ready) and the vector lane
//   sequencer.
//
//   Control side -> sequencer:
//     StartE     vector instruction valid in Execute
//     VecLenE    active lane count (LANE_W+1 bits, clamped to LANES inside)
//     MemOpE     instruction is a vector load/store
//     MemReadyM  data memory accepts the current group
//     Abort      cancel the current vector op (branch flush)
//   Sequencer -> control side:
//     StallVec   hold Fetch/Decode/Execute registers
//     LaneValid  a lane group is presented this cycle
//     LaneIdx    first lane index of the presented group
//     LaneMask   per-lane active bits of the presented group
//     Busy       sequencer is running groups
//     DoneE      one-cycle completion pulse
//
//   Modports: slave = the sequencer, master = whoever drives the controls.
// ---------------------------------------------------------------------------
interface vector_lane_sequencer_if #(
    parameter int LANES           = 8,
    parameter int LANES_PER_CYCLE = 2,
    parameter int LANE_W          = $clog2(LANES)
);
    logic                       StartE;
    logic [LANE_W:0]            VecLenE;
    logic                       MemOpE;
    logic                       MemReadyM;
    logic                       Abort;

    logic                       StallVec;
    logic                       LaneValid;
    logic [LANE_W-1:0]          LaneIdx;
    logic [LANES_PER_CYCLE-1:0] LaneMask;
    logic                       Busy;
    logic                       DoneE;

    modport master (
        output StartE, VecLenE, MemOpE, MemReadyM, Abort,
        input  StallVec, LaneValid, LaneIdx, LaneMask, Busy, DoneE
    );

    modport slave (
        input  StartE, VecLenE, MemOpE, MemReadyM, Abort,
        output StallVec, LaneValid, LaneIdx, LaneMask, Busy, DoneE
    );
endinterface

// File: rtl/vector_lane_sequencer.sv
// ---------------------------------------------------------------------------
// vector_lane_sequencer
//   Sequences one multi-cycle vector instruction in Execute across the vector
//   lanes, issuing LANES_PER_CYCLE lanes per accepted group and stalling the
//   front of the pipeline until the last group has been accepted.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     vif    vector_lane_sequencer_if.slave (StartE/VecLenE/MemOpE/MemReadyM/
//            Abort in; StallVec/LaneValid/LaneIdx/LaneMask/Busy/DoneE out)
//
//   Flow: IDLE captures the instruction (StallVec asserted combinationally in
//   that same cycle), RUN presents one group per cycle while memory accepts,
//   DONE pulses DoneE for one cycle so the instruction can move to Memory.
// ---------------------------------------------------------------------------
module vector_lane_sequencer #(
    parameter int LANES           = 8,
    parameter int LANES_PER_CYCLE = 2,
    parameter int LANE_W          = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   reset,
    vector_lane_sequencer_if.slave vif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LANE_W:0]   LEN_MAX  = (LANE_W+1)'(LANES);
    localparam logic [LANE_W:0]   STEP     = (LANE_W+1)'(LANES_PER_CYCLE);
    // One extra bit so base+STEP cannot overflow before the compare.
    localparam logic [LANE_W+1:0] STEP_EXT = (LANE_W+2)'(LANES_PER_CYCLE);

    state_t          state_q, state_d;
    logic [LANE_W:0] base_q,  base_d;
    logic [LANE_W:0] len_q,   len_d;
    logic            memop_q, memop_d;

    logic                       stall_vec;
    logic                       lane_valid;
    logic [LANE_W-1:0]          lane_idx;
    logic [LANES_PER_CYCLE-1:0] lane_mask;
    logic                       busy;
    logic                       done_e;

    logic            start_ok;
    logic            accept;
    logic            last_grp;
    logic [LANE_W:0] len_clamped;

    function automatic logic [LANE_W:0] clamp_len(input logic [LANE_W:0] v);
        if (v > LEN_MAX) begin
            return LEN_MAX;
        end
        return v;
    endfunction

    function automatic logic [LANES_PER_CYCLE-1:0] group_mask(
        input logic [LANE_W:0] base,
        input logic [LANE_W:0] len
    );
        logic [LANES_PER_CYCLE-1:0] m;
        m = '0;
        for (int i = 0; i < LANES_PER_CYCLE; i++) begin
            m[i] = (({1'b0, base} + (LANE_W+2)'(i)) < {1'b0, len});
        end
        return m;
    endfunction

    assign start_ok    = vif.StartE & ~vif.Abort;
    assign len_clamped = clamp_len(vif.VecLenE);
    assign accept      = ~memop_q | vif.MemReadyM;
    assign last_grp    = (({1'b0, base_q} + STEP_EXT) >= {1'b0, len_q});

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        memop_d    = memop_q;
        stall_vec  = 1'b0;
        lane_valid = 1'b0;
        lane_idx   = '0;
        lane_mask  = '0;
        busy       = 1'b0;
        done_e     = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall_vec = start_ok;
                if (start_ok) begin
                    len_d   = len_clamped;
                    memop_d = vif.MemOpE;
                    base_d  = '0;
                    state_d = (len_clamped == '0) ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                // LaneValid stays up in an Abort cycle; everything else drops.
                lane_valid = 1'b1;
                if (vif.Abort) begin
                    state_d = S_IDLE;
                    base_d  = '0;
                end else begin
                    lane_idx  = base_q[LANE_W-1:0];
                    lane_mask = group_mask(base_q, len_q);
                    stall_vec = 1'b1;
                    busy      = 1'b1;
                    if (accept) begin
                        if (last_grp) begin
                            state_d = S_DONE;
                        end else begin
                            base_d = base_q + STEP;
                        end
                    end
                end
            end

            S_DONE: begin
                // StartE here belongs to the instruction that is completing.
                done_e  = ~vif.Abort;
                base_d  = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                base_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            memop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            memop_q <= memop_d;
        end
    end

    assign vif.StallVec  = stall_vec;
    assign vif.LaneValid = lane_valid;
    assign vif.LaneIdx   = lane_idx;
    assign vif.LaneMask  = lane_mask;
    assign vif.Busy      = busy;
    assign vif.DoneE     = done_e;

endmodule
